// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad.
// Contents: matrix geometry, the key code type, the (row,col) -> key code
// mapping used by both the scanner and the keypad decode logic, and the press
// FSM state type.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_NUM  = KEY_ROWS * KEY_COLS;

  typedef logic [3:0] key_code_t;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } press_state_t;

  // Physical keypad legend: digits 1..9 in the 3x3 block, 0 below 8,
  // A..D down the right column, E and F either side of 0.
  function automatic key_code_t key_code_of(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    case ({row, col})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = 4'd10;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = 4'd11;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = 4'd12;
      4'hC:    code = 4'd14;
      4'hD:    code = 4'd0;
      4'hE:    code = 4'd15;
      4'hF:    code = 4'd13;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-matrix debouncer.
// A scanned frame is accepted into the key vector only after DEBOUNCE_SCANS
// consecutive identical frames.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   frame_end_i   one-cycle pulse: frame_i holds a complete frame
//   frame_i       scanned frame, bit k = key code k pressed
//   keys_o        debounced key vector
//   keys_upd_o    one-cycle pulse the cycle after keys_o was (re)loaded
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_end_i,
  input  logic [KEY_NUM-1:0] frame_i,
  output logic [KEY_NUM-1:0] keys_o,
  output logic               keys_upd_o
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  logic [KEY_NUM-1:0] prev_q;
  logic [KEY_NUM-1:0] keys_q;
  logic [SW-1:0]      stable_q;
  logic [SW-1:0]      stable_d;
  logic               upd_q;

  // A differing frame restarts the run at one: it is the first of a new run.
  always_comb begin
    stable_d = stable_q;
    if (frame_i == prev_q) begin
      stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
    end else begin
      stable_d = SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      keys_q   <= '0;
      stable_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (frame_end_i) begin
        stable_q <= stable_d;
        prev_q   <= frame_i;
        // Reload on every stable frame, including while saturated.
        if (stable_d == STABLE_MAX) begin
          keys_q <= frame_i;
          upd_q  <= 1'b1;
        end
      end
    end
  end

  assign keys_o     = keys_q;
  assign keys_upd_o = upd_q;

endmodule

// File: rtl/keypad_scanner.sv
// Active 4x4 keypad scanner.
// Drives one row low at a time, samples the columns, debounces complete
// frames and reports one event per debounced single-key press.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   row_n      row drive, active-low, exactly one row low
//   col_n      column sense, active-low, asynchronous to clk
//   keys       debounced key vector, bit k = key code k pressed
//   key_code   code of the last accepted press
//   key_valid  one-cycle strobe accompanying a new key_code
//   key_held   high while the accepted press is still down
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic [15:0] keys,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]         col_s1_q;
  logic [3:0]         col_s2_q;
  logic [DW-1:0]      dwell_q;
  logic [1:0]         row_q;
  logic [3:0]         row_n_q;
  logic [KEY_NUM-1:0] frame_q;
  logic [KEY_NUM-1:0] frame_d;
  logic               frame_end_q;
  logic               last_dwell;

  logic [KEY_NUM-1:0] keys_w;
  logic               keys_upd;

  press_state_t       state_q;
  press_state_t       state_d;
  key_code_t          code_q;
  key_code_t          code_d;
  key_code_t          hot_idx;
  logic               valid_q;
  logic               valid_d;
  logic               held_q;
  logic               held_d;

  // ---- Stage: column synchroniser ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
    end
  end

  // ---- Stage: row scan and frame capture ----
  // The row has been driven for SCAN_DIV-1 cycles by the last dwell cycle,
  // so the two-flop delayed columns belong to the current row.
  always_comb begin
    last_dwell = (dwell_q == DWELL_LAST);
    frame_d    = frame_q;
    if (last_dwell) begin
      for (int c = 0; c < KEY_COLS; c++) begin
        frame_d[key_code_of(row_q, 2'(c))] = ~col_s2_q[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q     <= '0;
      row_q       <= 2'd0;
      row_n_q     <= 4'b1110;
      frame_q     <= '0;
      frame_end_q <= 1'b0;
    end else begin
      dwell_q     <= last_dwell ? '0 : dwell_q + DW'(1);
      frame_q     <= frame_d;
      frame_end_q <= last_dwell && (row_q == 2'd3);
      if (last_dwell) begin
        row_q   <= row_q + 2'd1;
        row_n_q <= {row_n_q[2:0], row_n_q[3]};
      end
    end
  end

  // ---- Stage: debounce ----
  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_end_i(frame_end_q),
    .frame_i    (frame_q),
    .keys_o     (keys_w),
    .keys_upd_o (keys_upd)
  );

  // ---- Stage: press FSM ----
  always_comb begin
    hot_idx = '0;
    for (int k = 0; k < KEY_NUM; k++) begin
      if (keys_w[k]) hot_idx = 4'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Only a lone key starts a press; chords and ghosts are ignored until the
  // matrix is fully released.
  always_comb begin
    state_d = state_q;
    if (keys_upd) begin
      case (state_q)
        IDLE:    if ($onehot(keys_w)) state_d = HELD;
        HELD:    if (keys_w == '0)    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d = 1'b0;
    code_d  = code_q;
    held_d  = (state_d == HELD);
    if ((state_q == IDLE) && (state_d == HELD)) begin
      valid_d = 1'b1;
      code_d  = hot_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      held_q  <= held_d;
    end
  end

  assign row_n     = row_n_q;
  assign keys      = keys_w;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Active scanner for the 4x4 matrix keypad; drives the row lines and samples the column lines, i.e. the driving end of the 8-line keypad interface.
- Debounces full-matrix snapshots and emits one key-press event per debounced press: 4-bit key code plus a 1-cycle valid strobe.
- Also exports the debounced 16-bit active-high key vector in the same bit layout as the system key vector. Sits between the board keypad pins and the game/control FSMs.

Parameters:
- SCAN_DIV, 1000, clock cycles each row is held low (dwell); legal range >= 4.
- DEBOUNCE_SCANS, 8, consecutive identical full-matrix frames before a snapshot is accepted; legal range >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- row_n  out  4  keypad rows (pins bt[3:0]), active-low, at most one low at a time.
- col_n  in  4  keypad columns (pins bt[7:4]), active-low, asynchronous to clk, pulled up off-chip.
- keys  out  16  debounced key vector, 1 = pressed.
- key_code  out  4  code of the last accepted press.
- key_valid  out  1  1-cycle strobe; key_code is valid in the same cycle.
- key_held  out  1  high while the accepted key stays down.

Behaviour:
- Reset (async, rst=1): row_n=4'b1110 (row 0 active), keys=0, key_code=0, key_valid=0, key_held=0, dwell counter=0, row index=0, stable count=0, FSM=IDLE. Outputs never glitch during reset.
- Synchroniser: col_n passes through a 2-flop synchroniser reset to 4'b1111. It is not used for any other purpose.
- Scan: the dwell counter counts 0..SCAN_DIV-1 per row.
  - In the last dwell cycle, the synchronised columns for the current row are latched into the frame buffer as pressed = ~col.
  - The row index then advances 0->1->2->3->0 and row_n updates on the next edge.
  - One frame = 4*SCAN_DIV cycles.
- Key mapping, (row,col) -> code:
  - (3,1)=0, (0,0)=1, (0,1)=2, (0,2)=3
  - (1,0)=4, (1,1)=5, (1,2)=6
  - (2,0)=7, (2,1)=8, (2,2)=9
  - (0,3)=10, (1,3)=11, (2,3)=12, (3,3)=13
  - (3,0)=14, (3,2)=15
  - Frame bit k = key code k.
- Debounce at frame end (the cycle after the row-3 sample):
  - If frame == previous frame, stable count increments and saturates at DEBOUNCE_SCANS; otherwise stable count = 1.
  - The previous frame is then overwritten.
  - When stable count == DEBOUNCE_SCANS (first reach, or already saturated), keys is loaded with the frame on that edge.
- Press FSM, evaluated on the cycle keys is updated:
  - IDLE: keys has exactly one bit set -> key_code=index, key_valid=1 for one cycle, key_held=1, go HELD. keys has zero or two or more bits set -> stay IDLE, no strobe (ghost/chord rejection).
  - HELD: keys==0 -> key_held=0, go IDLE. Any other value -> stay HELD, no strobe, key_code unchanged. This covers a second key added or a key swap; a new event requires release to all-zero first.
- Press latency: from the column going stable to key_valid is at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- rst asserted mid-frame or mid-press: immediate return to the reset state. A key still held after reset re-triggers a press once it is debounced.
- The arithmetic widths are fixed by the parameters:
  - Dwell counter is $clog2(SCAN_DIV) bits.
  - Stable counter is $clog2(DEBOUNCE_SCANS+1) bits.

Decomposition:
- Shared package keypad_pkg holds:
  - KEY_ROWS=4, KEY_COLS=4.
  - Typedef key_code_t (4-bit).
  - The (row,col)->code mapping function, which the existing keypad decode logic also adopts.
  - FSM state enum {IDLE, HELD}.
- One natural sub-module: keypad_debounce, holding the frame comparison, stable counter and keys register.
- Scan counter, synchroniser and FSM stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame = 16 cycles):
- Reset then no key -> row_n cycles 1110, 1101, 1011, 0111, each held 4 cycles; keys=0; key_valid never asserts over 20 frames.
- Model holds (row1,col1) pressed -> exactly one key_valid, key_code=5, keys=16'h0020, key_held=1 within 4 frames + 3 cycles. Hold for 10 more frames -> no further strobe. Release -> key_held=0 after 3 stable frames.
- Key (3,1) bounces (toggling every 5 cycles for 2 frames, then stable) -> exactly one key_valid with key_code=0 after bouncing stops. No strobe during bouncing.
- Keys (0,0) and (0,1) pressed together from idle -> keys=16'h0006, no key_valid, key_held=0. Release (0,1) -> key_valid with key_code=1.
- Key 9 held, key 12 added, then key 9 released -> no new strobe, key_code stays 9. Release all, then press key 12 -> key_valid with code 12.
- rst pulsed mid-dwell of row 2 while key 15 is held -> outputs return to reset values asynchronously. After release of rst, key 15 is re-reported once (key_code=15) after debounce.
